// File: rtl/operand_reader_pkg.sv
// Shared definitions for the register-read stage: index width, stall causes
// and the per-source operand resolution helper.
package operand_reader_pkg;

    localparam int GPR_IDX_W = 5;

    typedef logic [GPR_IDX_W-1:0] gpr_idx_t;

    typedef enum logic [2:0] {
        OPRD_STALL_NONE   = 3'd0,
        OPRD_STALL_RS1    = 3'd1,
        OPRD_STALL_RS2    = 3'd2,
        OPRD_STALL_STRUCT = 3'd3,
        OPRD_STALL_BP     = 3'd4
    } stall_cause_t;

    typedef struct packed {
        logic [31:0] val;
        logic        hazard;
        logic        bypass;
    } src_res_t;

    // A source is clean when nothing is in flight for it, or when exactly one
    // write is pending and that write is landing this very cycle.
    function automatic src_res_t resolve_src(gpr_idx_t rs, logic [1:0] cnt,
                                             logic [31:0] gpr_val, logic wb_we,
                                             gpr_idx_t wb_rd, logic [31:0] wb_data);
        src_res_t res;
        res = '0;
        if (rs != '0) begin
            if (cnt == 2'd0) begin
                res.val = gpr_val;
            end else if (cnt == 2'd1 && wb_we && wb_rd == rs) begin
                res.val    = wb_data;
                res.bypass = 1'b1;
            end else begin
                res.hazard = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/operand_reader_if.sv
// Issue, writeback, execute-side and trace signals of the register-read stage.
interface operand_reader_if;
    import operand_reader_pkg::*;

    logic         in_valid;
    logic         in_ready;
    gpr_idx_t     rs1;
    gpr_idx_t     rs2;
    gpr_idx_t     rd;
    logic         rd_we;
    logic [31:0]  pc;
    logic [31:0]  gpr [1:31];
    logic         wb_we;
    gpr_idx_t     wb_rd;
    logic [31:0]  wb_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  rs1_val;
    logic [31:0]  rs2_val;
    gpr_idx_t     out_rd;
    logic         out_rd_we;
    logic [31:0]  out_pc;
    logic [31:0]  stall_cnt;
    logic         trace_accept;
    logic         trace_stall;
    logic         trace_bypass;
    logic         trace_err;
    stall_cause_t trace_cause;

    modport master (
        output in_valid, rs1, rs2, rd, rd_we, pc, gpr, wb_we, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, rs1_val, rs2_val, out_rd, out_rd_we, out_pc,
               stall_cnt, trace_accept, trace_stall, trace_bypass, trace_err, trace_cause
    );

    modport slave (
        input  in_valid, rs1, rs2, rd, rd_we, pc, gpr, wb_we, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, rs1_val, rs2_val, out_rd, out_rd_we, out_pc,
               stall_cnt, trace_accept, trace_stall, trace_bypass, trace_err, trace_cause
    );

endinterface

// File: rtl/operand_reader_gpr_scoreboard.sv
// Per-register count of outstanding writes (x1..x31), saturating in both
// directions; x0 has no entry.
module gpr_scoreboard
    import operand_reader_pkg::*;
#(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_en,
    input  gpr_idx_t   inc_rd,
    input  logic       dec_en,
    input  gpr_idx_t   dec_rd,
    input  gpr_idx_t   rs1,
    input  gpr_idx_t   rs2,
    input  gpr_idx_t   rd,
    output logic [1:0] cnt_rs1,
    output logic [1:0] cnt_rs2,
    output logic [1:0] cnt_rd,
    output logic       dec_err
);

    localparam logic [1:0] CNT_MAX = 2'(MAX_INFLIGHT);

    logic [1:0]  cnt [1:31];
    logic [31:1] inc_hit;
    logic [31:1] dec_hit;
    logic [1:0]  cnt_dec;

    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        for (int r = 1; r < 32; r++) begin
            inc_hit[r] = inc_en && (inc_rd == gpr_idx_t'(r));
            dec_hit[r] = dec_en && (dec_rd == gpr_idx_t'(r));
        end
    end

    assign cnt_rs1 = (rs1 == '0) ? 2'd0 : cnt[rs1];
    assign cnt_rs2 = (rs2 == '0) ? 2'd0 : cnt[rs2];
    assign cnt_rd  = (rd == '0)  ? 2'd0 : cnt[rd];
    assign cnt_dec = (dec_rd == '0) ? 2'd0 : cnt[dec_rd];

    // A writeback with nothing outstanding is a stray and leaves the count alone.
    assign dec_err = dec_en && (dec_rd != '0) && (cnt_dec == 2'd0)
                     && !(inc_en && inc_rd == dec_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < 32; r++) cnt[r] <= 2'd0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (inc_hit[r] && !dec_hit[r] && cnt[r] != CNT_MAX)
                    cnt[r] <= cnt[r] + 2'd1;
                else if (dec_hit[r] && !inc_hit[r] && cnt[r] != 2'd0)
                    cnt[r] <= cnt[r] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/operand_reader.sv
// Register-read stage: resolves rs1/rs2 against the GPR file, the writeback
// bypass and the scoreboard, and holds one operand slot for execute.
module operand_reader
    import operand_reader_pkg::*;
#(
    parameter int MAX_INFLIGHT = 3
) (
    input logic              clk,
    input logic              rst_n,
    input logic              en_trace,
    operand_reader_if.slave  bus
);

    logic [1:0]   cnt_rs1, cnt_rs2, cnt_rd;
    logic         dec_err;
    logic [31:0]  gpr_rs1, gpr_rs2;
    src_res_t     res1, res2;
    logic         struct_haz, hazard, in_ready, accept, wb_dec, rd_inc;
    stall_cause_t cause;

    logic         out_valid;
    logic [31:0]  rs1_val, rs2_val, out_pc, stall_cnt;
    gpr_idx_t     out_rd;
    logic         out_rd_we;

    assign wb_dec = bus.wb_we && (bus.wb_rd != '0);
    assign rd_inc = accept && bus.rd_we && (bus.rd != '0);

    gpr_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_en  (rd_inc),
        .inc_rd  (bus.rd),
        .dec_en  (wb_dec),
        .dec_rd  (bus.wb_rd),
        .rs1     (bus.rs1),
        .rs2     (bus.rs2),
        .rd      (bus.rd),
        .cnt_rs1 (cnt_rs1),
        .cnt_rs2 (cnt_rs2),
        .cnt_rd  (cnt_rd),
        .dec_err (dec_err)
    );

    assign gpr_rs1 = (bus.rs1 == '0) ? 32'd0 : bus.gpr[bus.rs1];
    assign gpr_rs2 = (bus.rs2 == '0) ? 32'd0 : bus.gpr[bus.rs2];

    assign res1 = resolve_src(bus.rs1, cnt_rs1, gpr_rs1, bus.wb_we, bus.wb_rd, bus.wb_data);
    assign res2 = resolve_src(bus.rs2, cnt_rs2, gpr_rs2, bus.wb_we, bus.wb_rd, bus.wb_data);

    // A full counter only blocks a new writer if no slot frees up this cycle.
    assign struct_haz = bus.rd_we && (bus.rd != '0) && (cnt_rd == 2'(MAX_INFLIGHT))
                        && !(wb_dec && bus.wb_rd == bus.rd);
    assign hazard   = res1.hazard || res2.hazard || struct_haz;
    assign in_ready = !hazard && (!out_valid || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        cause = OPRD_STALL_NONE;
        if (bus.in_valid && !in_ready) begin
            if (res1.hazard)      cause = OPRD_STALL_RS1;
            else if (res2.hazard) cause = OPRD_STALL_RS2;
            else if (struct_haz)  cause = OPRD_STALL_STRUCT;
            else                  cause = OPRD_STALL_BP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            rs1_val   <= '0;
            rs2_val   <= '0;
            out_rd    <= '0;
            out_rd_we <= 1'b0;
            out_pc    <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                rs1_val   <= res1.val;
                rs2_val   <= res2.val;
                out_rd    <= bus.rd;
                out_rd_we <= bus.rd_we;
                out_pc    <= bus.pc;
            end else if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
            end
            if (bus.in_valid && !in_ready && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.rs1_val      = rs1_val;
    assign bus.rs2_val      = rs2_val;
    assign bus.out_rd       = out_rd;
    assign bus.out_rd_we    = out_rd_we;
    assign bus.out_pc       = out_pc;
    assign bus.stall_cnt    = stall_cnt;
    assign bus.trace_accept = en_trace && accept;
    assign bus.trace_stall  = en_trace && bus.in_valid && !in_ready;
    assign bus.trace_bypass = en_trace && accept && (res1.bypass || res2.bypass);
    assign bus.trace_err    = en_trace && dec_err;
    assign bus.trace_cause  = en_trace ? cause : OPRD_STALL_NONE;

endmodule

// File: tb/tb_operand_reader.sv
// Directed bench for operand_reader: bypass, RAW stalls, saturation,
// backpressure and mid-operation reset.
module tb_operand_reader;
    import operand_reader_pkg::*;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic en_trace = 1'b1;
    int   checks   = 0;
    int   errors   = 0;
    int   expStall = 0;

    operand_reader_if bus ();

    operand_reader #(.MAX_INFLIGHT(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_trace (en_trace),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic rdWe, input logic [31:0] pc,
                                 input logic wbWe, input logic [4:0] wbRd,
                                 input logic [31:0] wbData, input logic outReady);
        bus.in_valid  = valid;
        bus.rs1       = rs1;
        bus.rs2       = rs2;
        bus.rd        = rd;
        bus.rd_we     = rdWe;
        bus.pc        = pc;
        bus.wb_we     = wbWe;
        bus.wb_rd     = wbRd;
        bus.wb_data   = wbData;
        bus.out_ready = outReady;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 1; i < 32; i++) bus.gpr[i] = 32'(i) << 8;
        bus.gpr[3] = 32'h0000_1234;
        bus.gpr[7] = 32'h0000_7777;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        #1;
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset stall_cnt", bus.stall_cnt, 32'd0);
        checkOutput("reset rs1_val", bus.rs1_val, 32'd0);
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean read of x3 with x0 as second source.
        applyStimulus(1, 3, 0, 0, 0, 32'h100, 0, 0, 0, 1);
        checkOutput("clean in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        checkOutput("clean out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("clean rs1_val", bus.rs1_val, 32'h1234);
        checkOutput("clean rs2_val", bus.rs2_val, 32'd0);
        checkOutput("clean pc", bus.out_pc, 32'h100);

        // RAW on x5, released by a same-cycle writeback bypass.
        applyStimulus(1, 0, 0, 5, 1, 32'h104, 0, 0, 0, 1);
        tick();
        checkOutput("producer rd", 32'(bus.out_rd), 32'd5);
        checkOutput("producer rd_we", 32'(bus.out_rd_we), 32'd1);
        applyStimulus(1, 5, 0, 0, 0, 32'h108, 0, 0, 0, 1);
        checkOutput("raw in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("raw cause", 32'(bus.trace_cause), 32'(OPRD_STALL_RS1));
        tick(); expStall++;
        checkOutput("raw stall 1", bus.stall_cnt, 32'(expStall));
        tick(); expStall++;
        checkOutput("raw stall 2", bus.stall_cnt, 32'(expStall));
        applyStimulus(1, 5, 0, 0, 0, 32'h108, 1, 5, 32'hDEAD, 1);
        checkOutput("bypass in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("bypass trace", 32'(bus.trace_bypass), 32'd1);
        tick();
        checkOutput("bypass rs1_val", bus.rs1_val, 32'hDEAD);
        checkOutput("bypass pc", bus.out_pc, 32'h108);
        checkOutput("bypass stall held", bus.stall_cnt, 32'(expStall));

        // Two producers of x7: one writeback is not enough.
        applyStimulus(1, 0, 0, 7, 1, 32'h10C, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 0, 0, 7, 1, 32'h110, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 0, 7, 0, 0, 32'h114, 1, 7, 32'hAAAA, 1);
        checkOutput("dbl in_ready wb1", 32'(bus.in_ready), 32'd0);
        tick(); expStall++;
        applyStimulus(1, 0, 7, 0, 0, 32'h114, 0, 0, 0, 1);
        checkOutput("dbl in_ready cnt1", 32'(bus.in_ready), 32'd0);
        checkOutput("dbl cause", 32'(bus.trace_cause), 32'(OPRD_STALL_RS2));
        applyStimulus(0, 0, 7, 0, 0, 32'h114, 1, 7, 32'hBBBB, 1);
        tick();
        applyStimulus(1, 0, 7, 0, 0, 32'h114, 0, 0, 0, 1);
        checkOutput("dbl in_ready clear", 32'(bus.in_ready), 32'd1);
        tick();
        checkOutput("dbl rs2_val", bus.rs2_val, 32'h7777);
        checkOutput("dbl pc", bus.out_pc, 32'h114);

        // Saturate x9, then a fourth writer rides on a simultaneous writeback.
        applyStimulus(1, 0, 0, 9, 1, 32'h118, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 0, 0, 9, 1, 32'h11C, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 0, 0, 9, 1, 32'h120, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 0, 0, 9, 1, 32'h124, 0, 0, 0, 1);
        checkOutput("sat in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("sat cause", 32'(bus.trace_cause), 32'(OPRD_STALL_STRUCT));
        tick(); expStall++;
        applyStimulus(1, 0, 0, 9, 1, 32'h124, 1, 9, 32'hCCCC, 1);
        checkOutput("sat wb in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        checkOutput("sat pc", bus.out_pc, 32'h124);
        applyStimulus(1, 0, 0, 9, 1, 32'h128, 0, 0, 0, 1);
        checkOutput("sat still full", 32'(bus.in_ready), 32'd0);

        // Backpressure for four cycles, then release.
        applyStimulus(1, 3, 0, 0, 0, 32'h200, 0, 0, 0, 0);
        checkOutput("bp in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("bp cause", 32'(bus.trace_cause), 32'(OPRD_STALL_BP));
        for (int i = 0; i < 4; i++) begin
            tick(); expStall++;
            checkOutput("bp hold pc", bus.out_pc, 32'h124);
            checkOutput("bp hold valid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp hold in_ready", 32'(bus.in_ready), 32'd0);
        end
        checkOutput("bp stall_cnt", bus.stall_cnt, 32'(expStall));
        checkOutput("bp stall abs", bus.stall_cnt, 32'd8);
        applyStimulus(1, 3, 0, 0, 0, 32'h200, 0, 0, 0, 1);
        checkOutput("bp release in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        checkOutput("bp load pc", bus.out_pc, 32'h200);
        checkOutput("bp load rs1", bus.rs1_val, 32'h1234);

        // Reset in the middle of a stall on x5.
        applyStimulus(1, 0, 0, 5, 1, 32'h204, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 5, 0, 0, 0, 32'h208, 0, 0, 0, 1);
        checkOutput("rst pre in_ready", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst async valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst async stall", bus.stall_cnt, 32'd0);
        checkOutput("rst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 5, 0, 0, 0, 32'h208, 1, 5, 32'h5555, 1);
        checkOutput("stray wb err", 32'(bus.trace_err), 32'd1);
        tick();
        applyStimulus(1, 5, 0, 0, 0, 32'h208, 0, 0, 0, 1);
        checkOutput("post rst in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        checkOutput("post rst rs1", bus.rs1_val, 32'h500);
        checkOutput("post rst stall", bus.stall_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_reader.md
Name: operand_reader

Overview:
- Register-read stage: the read side of the GPR file that the writeback stage fills.
- Accepts decoded instructions over a valid/ready handshake and reads rs1/rs2 from the GPR array.
- Tracks in-flight destination writes in a per-register scoreboard, bypasses same-cycle writeback data, and stalls on unresolved RAW hazards.
- Presents operands to the execute stage through one registered output slot.

Parameters:
MAX_INFLIGHT, 3, maximum outstanding writes per destination register (scoreboard counter saturation value, 2-bit counter)

Ports:
_clk  input  1  clock, all state on posedge
_reset  input  1  asynchronous reset, active-low
_in_valid  input  1  decoded instruction present
in_ready_  output  1  stage accepts instruction this cycle
_rs1  input  5  source register 1 index
_rs2  input  5  source register 2 index
_rd  input  5  destination register index
_rd_we  input  1  instruction writes rd
_pc  input  32  instruction PC
_gpr[31:1]  input  32 each  architectural register file contents
_wb_we  input  1  writeback stage writes a register this cycle
_wb_rd  input  5  writeback destination
_wb_data  input  32  writeback value (already source-muxed)
out_valid_  output  1  operands valid for execute
_out_ready  input  1  execute consumes operands
rs1_val_  output  32  operand 1
rs2_val_  output  32  operand 2
rd_  output  5  passed-through rd
rd_we_  output  1  passed-through rd_we
pc_  output  32  passed-through PC
stall_cnt_  output  32  cycles with _in_valid=1 and in_ready_=0
_en_trace  input  1  enables LOG tracing

Behaviour:
- Reset (_reset=0, async):
  - out_valid_=0; rs1_val_, rs2_val_, pc_, rd_ = 0; rd_we_=0; stall_cnt_=0.
  - All scoreboard counters = 0.
  - in_ready_ is combinational and therefore equals !hazard while out_valid_=0.
- Reading x0 always yields 0. x0 is never counted, set or cleared in the scoreboard.
- Scoreboard cnt[r], 2-bit, r=1..31:
  - Increments on accept when _rd_we=1 and _rd!=0.
  - Decrements when _wb_we=1 and _wb_rd!=0.
  - Both in the same cycle for the same r: count unchanged.
  - A decrement at 0 is ignored and traced as an error. No wrap-around in either direction.
- Source resolution for rsN, evaluated combinationally:
  - rsN=0: value 0, no hazard.
  - cnt[rsN]=0: value _gpr[rsN].
  - cnt[rsN]=1 and _wb_we=1 and _wb_rd=rsN: value _wb_data (bypass).
  - Otherwise: hazard.
- Structural hazard: _rd_we=1 and _rd!=0 and cnt[_rd]=MAX_INFLIGHT and no same-cycle decrement of _rd.
- in_ready_ = !hazard && (!out_valid_ || _out_ready).
- Accept = _in_valid && in_ready_. On accept, next posedge:
  - Load rs1_val_, rs2_val_, rd_, rd_we_, pc_.
  - out_valid_=1.
  - Update the scoreboard.
- When out_valid_ && _out_ready && !accept: out_valid_ goes to 0 next posedge.
- Latency and throughput:
  - 1 cycle from accept to out_valid_.
  - Full throughput when there are no hazards and _out_ready=1.
- While out_valid_=1 and _out_ready=0: all outputs hold stable and in_ready_=0.
- stall_cnt_ increments each cycle with _in_valid && !in_ready_. It saturates at 32'hFFFFFFFF.
- Trace (_en_trace=1): each accept, each stall cycle (with cause: rs1/rs2/structural/backpressure), and each bypass.
- Mid-operation reset:
  - Clears all in-flight scoreboard state and output valid immediately.
  - Any pending writebacks after reset are treated as stray decrements: ignored and traced.

Decomposition:
- Shared decoder header holds the hazard-cause constants: OPRD_STALL_NONE, _RS1, _RS2, _STRUCT, _BP.
- Shared header also holds the register-index width `GPR_IDX_W=5`.
- One natural sub-module, gpr_scoreboard:
  - Owns the 31 counters and the inc/dec/saturation rules.
  - Exposes cnt lookups for rs1, rs2 and rd.

Test Plan:
- Reset then send rs1=3, rs2=0, with _gpr[3]=32'h1234 and scoreboard empty -> next cycle out_valid_=1, rs1_val_=32'h1234, rs2_val_=0.
- Back-to-back RAW:
  - Issue A with rd=5, _rd_we=1; then B with rs1=5 and no writeback -> in_ready_=0 and stall_cnt_ increments each cycle.
  - Then _wb_we=1, _wb_rd=5, _wb_data=32'hDEAD -> B is accepted the same cycle with rs1_val_=32'hDEAD.
- Double producer: two issues with rd=7 (cnt=2), then one writeback of x7 -> a reader of x7 still stalls. After the second writeback -> the reader proceeds with the _gpr[7] value.
- Saturation: three issues with rd=9 -> a fourth writer of rd=9 stalls (structural). A simultaneous x9 writeback lets it through and cnt stays 3.
- Backpressure: out_valid_=1 with _out_ready=0 for 4 cycles -> outputs unchanged, in_ready_=0, stall_cnt_ +4. Raising _out_ready -> the next instruction loads at the following edge.
- Assert _reset low mid-stall with cnt[5]=1 -> out_valid_=0 asynchronously, scoreboard clears, and a subsequent read of x5 proceeds without stall.
